// File: rtl/f5_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : f5_sweep_ctrl
// Description : Sweeps a two-input NAND datapath through its four minterms,
//               cross-checks both implementations and reports the results.
// Revision    : 1.0 - initial release
// ============================================================================
module f5_sweep_ctrl #(
    parameter int         SETTLE = 1,
    parameter logic [3:0] EXPECT = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sa,
    input  logic       sb,
    output logic       x,
    output logic       y,
    output logic [1:0] m,
    output logic       busy,
    output logic       done,
    output logic [3:0] fail_mask,
    output logic [2:0] err_cnt,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] c_SETTLE_LAST = 3'(SETTLE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [1:0] w_m_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic [3:0] w_mask_nxt;
    logic [2:0] w_err_nxt;
    logic       w_pass_nxt;
    logic       w_fail;

    assign w_fail = (sa != EXPECT[m]) || (sb != EXPECT[m]) || (sa != sb);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_m_nxt     = m;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_mask_nxt  = fail_mask;
        w_err_nxt   = err_cnt;
        w_pass_nxt  = pass;
        case (r_state)
            IDLE: begin
                w_m_nxt    = 2'd0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = APPLY;
                    w_cnt_nxt   = 3'd0;
                    w_busy_nxt  = 1'b1;
                    w_mask_nxt  = 4'b0000;
                    w_err_nxt   = 3'd0;
                    w_pass_nxt  = 1'b0;
                end
            end
            APPLY: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_cnt_nxt = 3'd0;
                    // Each minterm is sampled exactly once, so the count tops out at 4.
                    if (w_fail) begin
                        w_mask_nxt = fail_mask | (4'b0001 << m);
                        if (err_cnt != 3'd4) begin
                            w_err_nxt = err_cnt + 3'd1;
                        end
                    end
                    if (m == 2'd3) begin
                        w_state_nxt = DONE;
                        w_m_nxt     = 2'd0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_mask_nxt == 4'b0000);
                    end else begin
                        w_m_nxt = m + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_m_nxt     = 2'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Gate inputs follow the minterm index; m is held at 0 outside APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            m         <= 2'd0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail_mask <= 4'b0000;
            err_cnt   <= 3'd0;
            pass      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            m         <= w_m_nxt;
            x         <= w_m_nxt[1];
            y         <= w_m_nxt[0];
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            fail_mask <= w_mask_nxt;
            err_cnt   <= w_err_nxt;
            pass      <= w_pass_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_f5_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_f5_sweep_ctrl
// Description : Self-checking bench for f5_sweep_ctrl (SETTLE=1 and SETTLE=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f5_sweep_ctrl;

    localparam logic [3:0] c_EXPECT = 4'b0111;

    typedef struct {
        logic [3:0] ta;
        logic [3:0] tb;
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [3:0] ta1 = 4'b0111, tb1 = 4'b0111, ta3 = 4'b0111, tb3 = 4'b0111;
    logic       sa1, sb1, sa3, sb3;
    logic       x1, y1, busy1, done1, pass1;
    logic       x3, y3, busy3, done3, pass3;
    logic [1:0] m1, m3;
    logic [3:0] mask1, mask3;
    logic [2:0] err1, err3;

    int tests  = 0;
    int errors = 0;
    int sel    = 1;

    logic       cx, cy, cbusy, cdone, cpass;
    logic [1:0] cm;
    logic [3:0] cmask;
    logic [2:0] cerr;

    // Each truth table models one gate implementation, indexed by {a,b}.
    assign sa1 = ta1[{x1, y1}];
    assign sb1 = tb1[{x1, y1}];
    assign sa3 = ta3[{x3, y3}];
    assign sb3 = tb3[{x3, y3}];

    f5_sweep_ctrl #(.SETTLE(1), .EXPECT(4'b0111)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sa(sa1), .sb(sb1),
        .x(x1), .y(y1), .m(m1), .busy(busy1), .done(done1),
        .fail_mask(mask1), .err_cnt(err1), .pass(pass1)
    );

    f5_sweep_ctrl #(.SETTLE(3), .EXPECT(4'b0111)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .sa(sa3), .sb(sb3),
        .x(x3), .y(y3), .m(m3), .busy(busy3), .done(done3),
        .fail_mask(mask3), .err_cnt(err3), .pass(pass3)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel == 3) begin
            cx = x3; cy = y3; cm = m3; cbusy = busy3; cdone = done3;
            cmask = mask3; cerr = err3; cpass = pass3;
        end else begin
            cx = x1; cy = y1; cm = m1; cbusy = busy1; cdone = done1;
            cmask = mask1; cerr = err1; cpass = pass1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a minterm fails when either gate disagrees with the table or each other.
    function automatic vec_t model(input logic [3:0] a, input logic [3:0] b);
        vec_t v;
        v.ta = a; v.tb = b; v.mask = 4'b0000; v.cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] != c_EXPECT[i] || b[i] != c_EXPECT[i] || a[i] != b[i]) begin
                v.mask[i] = 1'b1;
                v.cnt     = v.cnt + 3'd1;
            end
        end
        v.pass = (v.mask == 4'b0000);
        return v;
    endfunction

    // Called on a negedge in an IDLE cycle; returns on a negedge in the following IDLE cycle.
    task automatic run(input int s, input vec_t v, input logic hold, input string name);
        int mm;
        sel = s;
        if (s == 3) begin ta3 = v.ta; tb3 = v.tb; start3 = 1'b1; end
        else begin ta1 = v.ta; tb1 = v.tb; start1 = 1'b1; end
        @(negedge clk);
        if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
        chk({name, " cleared"}, int'({cmask, cerr, cpass}), 0);
        for (int k = 0; k < 4 * s; k++) begin
            if (k > 0) @(negedge clk);
            mm = k / s;
            chk({name, " apply"}, int'({cx, cy, cm, cbusy, cdone}),
                int'({mm[1], mm[0], mm[1:0], 1'b1, 1'b0}));
        end
        @(negedge clk);
        chk({name, " done_cycle"}, int'({cx, cy, cm, cbusy, cdone}), 32'b000001);
        chk({name, " fail_mask"}, int'(cmask), int'(v.mask));
        chk({name, " err_cnt"}, int'(cerr), int'(v.cnt));
        chk({name, " pass"}, int'(cpass), int'(v.pass));
        @(negedge clk);
        chk({name, " idle_hold"}, int'({cbusy, cdone, cmask, cerr, cpass}),
            int'({1'b0, 1'b0, v.mask, v.cnt, v.pass}));
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        vecs[0] = '{ta: 4'b0111, tb: 4'b0111, mask: 4'b0000, cnt: 3'd0, pass: 1'b1};
        vecs[1] = '{ta: 4'b0111, tb: 4'b0000, mask: 4'b0111, cnt: 3'd3, pass: 1'b0};
        vecs[2] = '{ta: 4'b1000, tb: 4'b0111, mask: 4'b1111, cnt: 3'd4, pass: 1'b0};
        vecs[3] = '{ta: 4'b1111, tb: 4'b0111, mask: 4'b1000, cnt: 3'd1, pass: 1'b0};
        vecs[4] = '{ta: 4'b0110, tb: 4'b0110, mask: 4'b0001, cnt: 3'd1, pass: 1'b0};
        vecs[5] = '{ta: 4'b0111, tb: 4'b0011, mask: 4'b0100, cnt: 3'd1, pass: 1'b0};

        #1 rst_n = 1'b0;
        #6;
        chk("reset1", int'({x1, y1, m1, busy1, done1, mask1, err1, pass1}), 0);
        chk("reset3", int'({x3, y3, m3, busy3, done3, mask3, err3, pass3}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run(1, vecs[i], 1'b0, $sformatf("vec%0d", i));
        run(3, vecs[0], 1'b0, "settle3_nand");
        run(3, vecs[1], 1'b0, "settle3_sb0");

        // start held high: one run only, then re-sampled in IDLE with fresh results
        run(1, vecs[2], 1'b1, "hold_run1");
        run(1, vecs[0], 1'b0, "hold_run2");

        for (int r = 0; r < 16; r++) begin
            rv = model(4'($urandom), 4'($urandom));
            run((r % 4 == 3) ? 3 : 1, rv, 1'b0, $sformatf("rand%0d", r));
        end

        // asynchronous reset while minterm 2 is applied
        sel = 1; ta1 = 4'b0111; tb1 = 4'b0000; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset", int'({m1, busy1, mask1, err1}), int'({2'd2, 1'b1, 4'b0011, 3'd2}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", int'({x1, y1, m1, busy1, done1, mask1, err1, pass1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_done_after_reset", int'({busy1, done1}), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
